// File: rtl/i2c_slave_fsm_if.sv
// Open-drain I2C bus plus the byte-side handshake of the slave target.
// SDA is a wired-AND: any side pulling low wins, otherwise the pull-up holds it high.
`timescale 1ns/1ps

interface i2c_slave_fsm_if;
  logic       i2c_scl;
  logic       i2c_sda;
  logic       master_sda_oe;
  logic       sda_oe;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       addr_match;
  logic       busy;

  assign i2c_sda = ~(sda_oe | master_sda_oe);

  modport slave (
    input  i2c_scl,
    input  i2c_sda,
    input  tx_data,
    output sda_oe,
    output rx_data,
    output rx_valid,
    output tx_req,
    output addr_match,
    output busy
  );

  modport master (
    output i2c_scl,
    output master_sda_oe,
    output tx_data,
    input  i2c_sda,
    input  sda_oe,
    input  rx_data,
    input  rx_valid,
    input  tx_req,
    input  addr_match,
    input  busy
  );
endinterface

// File: rtl/i2c_slave_fsm.sv
// I2C slave target: oversamples SCL/SDA, detects START/STOP, ACKs its 7-bit address,
// receives write bytes onto rx_data and shifts out read bytes taken from tx_data.
`timescale 1ns/1ps

module i2c_slave_fsm #(
  parameter logic [6:0] SLAVE_ADDR = 7'h48
) (
  input logic            clk,
  input logic            reset_n,
  i2c_slave_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_t;

  logic       scl_s1_q, scl_s2_q, scl_prev_q;
  logic       sda_s1_q, sda_s2_q, sda_prev_q;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       phase_q, phase_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       addr_match_q, addr_match_d;
  logic       busy_q, busy_d;

  logic       scl_rise, scl_fall;
  logic       start_det, stop_det;
  logic [7:0] byte_in;

  // Bus conditions are judged on the second synchronizer stage against its previous value.
  assign scl_rise  = scl_s2_q & ~scl_prev_q;
  assign scl_fall  = ~scl_s2_q & scl_prev_q;
  assign start_det = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;
  assign byte_in   = {shift_q[6:0], sda_s2_q};

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    phase_d      = phase_q;
    rw_d         = rw_q;
    sda_oe_d     = sda_oe_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    tx_req_d     = 1'b0;
    addr_match_d = addr_match_q;

    if (stop_det) begin
      state_d      = IDLE;
      sda_oe_d     = 1'b0;
      addr_match_d = 1'b0;
      phase_d      = 1'b0;
    end else if (start_det) begin
      state_d      = ADDR;
      sda_oe_d     = 1'b0;
      addr_match_d = 1'b0;
      phase_d      = 1'b0;
      bit_cnt_d    = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          sda_oe_d = 1'b0;
        end

        ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = 3'd0;
              rw_d      = byte_in[0];
              phase_d   = 1'b0;
              // The general-call address is never claimed, whatever SLAVE_ADDR is set to.
              if ((byte_in[7:1] == SLAVE_ADDR) && (byte_in[7:1] != 7'h00))
                state_d = ADDR_ACK;
              else
                state_d = WAIT_STOP;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d     = 1'b1;
              addr_match_d = 1'b1;
              phase_d      = 1'b1;
            end else begin
              phase_d   = 1'b0;
              bit_cnt_d = 3'd0;
              if (rw_q) begin
                shift_d  = bus.tx_data;
                tx_req_d = 1'b1;
                sda_oe_d = ~bus.tx_data[7];
                state_d  = RD_DATA;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = WR_DATA;
              end
            end
          end
        end

        WR_DATA: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d  = 3'd0;
              rx_data_d  = byte_in;
              rx_valid_d = 1'b1;
              phase_d    = 1'b0;
              state_d    = WR_ACK;
            end
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              phase_d   = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = WR_DATA;
            end
          end
        end

        // Bit 7 is already on the wire on entry; falls 1-7 present bits 6..0, fall 8 releases.
        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              phase_d   = 1'b0;
              state_d   = RD_ACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end

        RD_ACK: begin
          if (!phase_q) begin
            if (scl_rise) begin
              if (sda_s2_q)
                state_d = WAIT_STOP;
              else
                phase_d = 1'b1;
            end
          end else if (scl_fall) begin
            phase_d   = 1'b0;
            bit_cnt_d = 3'd0;
            shift_d   = bus.tx_data;
            tx_req_d  = 1'b1;
            sda_oe_d  = ~bus.tx_data[7];
            state_d   = RD_DATA;
          end
        end

        WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // Synchronizers reset to the idle-high bus level so reset release never looks like a START.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_s1_q     <= 1'b1;
      scl_s2_q     <= 1'b1;
      scl_prev_q   <= 1'b1;
      sda_s1_q     <= 1'b1;
      sda_s2_q     <= 1'b1;
      sda_prev_q   <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      phase_q      <= 1'b0;
      rw_q         <= 1'b0;
      sda_oe_q     <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      tx_req_q     <= 1'b0;
      addr_match_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      scl_s1_q     <= bus.i2c_scl;
      scl_s2_q     <= scl_s1_q;
      scl_prev_q   <= scl_s2_q;
      sda_s1_q     <= bus.i2c_sda;
      sda_s2_q     <= sda_s1_q;
      sda_prev_q   <= sda_s2_q;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      phase_q      <= phase_d;
      rw_q         <= rw_d;
      sda_oe_q     <= sda_oe_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      tx_req_q     <= tx_req_d;
      addr_match_q <= addr_match_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.sda_oe     = sda_oe_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.tx_req     = tx_req_q;
  assign bus.addr_match = addr_match_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_fsm.sv
// Directed bench for i2c_slave_fsm: the bench plays the I2C master with SCL at 1/16 of clk
// and checks ACKs, read-back bits, handshake pulses and busy timing against hand-computed values.
`timescale 1ns/1ps

module tb_i2c_slave_fsm;

  localparam int Q = 4;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  i2c_slave_fsm_if bus ();

  i2c_slave_fsm #(.SLAVE_ADDR(7'h48)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  int rx_pulses  = 0;
  int tx_pulses  = 0;
  int oe_cycles  = 0;
  int match_cyc  = 0;
  logic [7:0] rx_log[$];

  // Pulse/level monitors sample on the falling clk edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.rx_valid) begin
      rx_pulses++;
      rx_log.push_back(bus.rx_data);
    end
    if (bus.tx_req)     tx_pulses++;
    if (bus.sda_oe)     oe_cycles++;
    if (bus.addr_match) match_cyc++;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
    logic       exp_ack;
    int         exp_rx;
  } vec_t;

  vec_t vecs[6];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_bit(input logic b, output logic sampled, output logic slave_oe);
    bus.i2c_scl = 1'b0;
    wait_q();
    bus.master_sda_oe = ~b;
    wait_q();
    bus.i2c_scl = 1'b1;
    wait_q();
    sampled  = bus.i2c_sda;
    slave_oe = bus.sda_oe;
    wait_q();
  endtask

  task automatic bus_start();
    bus.i2c_scl = 1'b0;
    wait_q();
    bus.master_sda_oe = 1'b0;
    wait_q();
    bus.i2c_scl = 1'b1;
    wait_q();
    bus.master_sda_oe = 1'b1;
    wait_q();
  endtask

  task automatic bus_stop(output logic busy_before, output logic busy_after);
    bus.i2c_scl = 1'b0;
    wait_q();
    bus.master_sda_oe = 1'b1;
    wait_q();
    bus.i2c_scl = 1'b1;
    wait_q();
    bus.master_sda_oe = 1'b0;
    repeat (2) @(negedge clk);
    busy_before = bus.busy;
    @(negedge clk);
    busy_after = bus.busy;
    wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic s, oe;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s, oe);
    bus_bit(1'b1, s, oe);
    acked = (s == 1'b0) && oe;
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] b, output logic oe9);
    logic s, oe;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s, oe);
      b[i] = s;
    end
    bus_bit(~master_ack, s, oe9);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_sda_oe"},     bus.sda_oe,     1'b0);
    check_output({tag, "_rx_data"},    bus.rx_data,    8'h00);
    check_output({tag, "_rx_valid"},   bus.rx_valid,   1'b0);
    check_output({tag, "_tx_req"},     bus.tx_req,     1'b0);
    check_output({tag, "_addr_match"}, bus.addr_match, 1'b0);
    check_output({tag, "_busy"},       bus.busy,       1'b0);
  endtask

  initial begin
    logic       ack, bb, ba, oe9;
    logic [7:0] rd0, rd1;
    logic [7:0] aw, ar;
    int         rx0, tx0, oe0, m0;

    vecs[0] = '{addr: 7'h48, data: 8'h3C, exp_ack: 1'b1, exp_rx: 1};
    vecs[1] = '{addr: 7'h50, data: 8'hFF, exp_ack: 1'b0, exp_rx: 0};
    vecs[2] = '{addr: 7'h00, data: 8'h12, exp_ack: 1'b0, exp_rx: 0};
    vecs[3] = '{addr: 7'h49, data: 8'h81, exp_ack: 1'b0, exp_rx: 0};
    vecs[4] = '{addr: 7'h48, data: 8'h00, exp_ack: 1'b1, exp_rx: 1};
    vecs[5] = '{addr: 7'h48, data: 8'hFF, exp_ack: 1'b1, exp_rx: 1};

    aw = {7'h48, 1'b0};
    ar = {7'h48, 1'b1};

    reset_n           = 1'b0;
    bus.i2c_scl       = 1'b1;
    bus.master_sda_oe = 1'b0;
    bus.tx_data       = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single-byte writes: matching and non-matching addresses.
    for (int v = 0; v < 6; v++) begin
      rx0 = rx_pulses;
      oe0 = oe_cycles;
      m0  = match_cyc;
      bus_start();
      write_byte({vecs[v].addr, 1'b0}, ack);
      check_output($sformatf("v%0d_addr_ack", v), ack, vecs[v].exp_ack);
      write_byte(vecs[v].data, ack);
      check_output($sformatf("v%0d_data_ack", v), ack, vecs[v].exp_ack);
      bus_stop(bb, ba);
      check_output($sformatf("v%0d_busy_before_stop", v), bb, 1'b1);
      check_output($sformatf("v%0d_busy_after_stop", v), ba, 1'b0);
      check_output($sformatf("v%0d_rx_pulses", v), rx_pulses - rx0, vecs[v].exp_rx);
      if (vecs[v].exp_ack)
        check_output($sformatf("v%0d_rx_data", v), rx_log[$], vecs[v].data);
      else begin
        check_output($sformatf("v%0d_oe_never", v), oe_cycles - oe0, 0);
        check_output($sformatf("v%0d_match_never", v), match_cyc - m0, 0);
      end
    end

    // Two-byte write.
    rx0 = rx_pulses;
    bus_start();
    write_byte(aw, ack);
    check_output("wr2_addr_ack", ack, 1'b1);
    write_byte(8'hA5, ack);
    check_output("wr2_ack0", ack, 1'b1);
    write_byte(8'h5A, ack);
    check_output("wr2_ack1", ack, 1'b1);
    bus_stop(bb, ba);
    check_output("wr2_busy_after_stop", ba, 1'b0);
    check_output("wr2_rx_pulses", rx_pulses - rx0, 2);
    check_output("wr2_rx_first", rx_log[rx_log.size() - 2], 8'hA5);
    check_output("wr2_rx_second", rx_log[rx_log.size() - 1], 8'h5A);

    // Read of 0xAA with master NACK.
    bus.tx_data = 8'hAA;
    tx0 = tx_pulses;
    bus_start();
    write_byte(ar, ack);
    check_output("rd_addr_ack", ack, 1'b1);
    read_byte(1'b0, rd0, oe9);
    check_output("rd_byte", rd0, 8'hAA);
    check_output("rd_released_9th", oe9, 1'b0);
    check_output("rd_tx_req_count", tx_pulses - tx0, 1);
    check_output("rd_addr_match_wait_stop", bus.addr_match, 1'b1);
    check_output("rd_busy_wait_stop", bus.busy, 1'b1);
    bus_stop(bb, ba);
    check_output("rd_busy_after_stop", ba, 1'b0);
    check_output("rd_addr_match_after_stop", bus.addr_match, 1'b0);

    // Write address, repeated START, then two read bytes (ACK then NACK).
    bus.tx_data = 8'h11;
    tx0 = tx_pulses;
    rx0 = rx_pulses;
    bus_start();
    write_byte(aw, ack);
    check_output("rs_wr_addr_ack", ack, 1'b1);
    bus_start();
    write_byte(ar, ack);
    check_output("rs_rd_addr_ack", ack, 1'b1);
    read_byte(1'b1, rd0, oe9);
    bus.tx_data = 8'h22;
    read_byte(1'b0, rd1, oe9);
    check_output("rs_byte0", rd0, 8'h11);
    check_output("rs_byte1", rd1, 8'h22);
    check_output("rs_tx_req_count", tx_pulses - tx0, 2);
    check_output("rs_no_rx", rx_pulses - rx0, 0);
    bus_stop(bb, ba);
    check_output("rs_busy_after_stop", ba, 1'b0);

    // Reset asserted while the address ACK is on the wire.
    rx0 = rx_pulses;
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(aw[i], ack, oe9);
    bus.i2c_scl = 1'b0;
    for (int k = 0; k < 8 && !bus.sda_oe; k++) @(negedge clk);
    check_output("rst_ack_driven", bus.sda_oe, 1'b1);
    reset_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    wait_q();
    bus.i2c_scl = 1'b1;
    wait_q();
    wait_q();
    write_byte(8'h77, ack);
    check_output("rst_no_ack_after", ack, 1'b0);
    check_output("rst_no_rx", rx_pulses - rx0, 0);
    check_output("rst_idle_busy", bus.busy, 1'b0);
    bus_stop(bb, ba);
    check_output("rst_busy_after_stop", ba, 1'b0);
    bus_start();
    write_byte(aw, ack);
    check_output("rst_fresh_addr_ack", ack, 1'b1);
    write_byte(8'h99, ack);
    check_output("rst_fresh_data_ack", ack, 1'b1);
    bus_stop(bb, ba);
    check_output("rst_fresh_rx_pulses", rx_pulses - rx0, 1);
    check_output("rst_fresh_rx_data", rx_log[$], 8'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/i2c_slave_fsm.md
# i2c_slave_fsm

Slave-side I2C target that sits on the bus downstream of the master FSM. It oversamples SCL/SDA with the system clock and detects START/STOP. It matches a 7-bit address and ACKs it, then either receives write bytes and presents them on `rx_data`, or shifts out read bytes taken from `tx_data`. SDA is open-drain: the block only ever pulls it low or releases it.

## Interface
- `SLAVE_ADDR`, 7'h48, 7-bit address this target responds to.
- `clk`  input  1  system clock; must run at ≥8× the SCL frequency.
- `reset_n`  input  1  asynchronous, active-low reset.
- `i2c_scl`  input  1  bus clock; the slave never drives it and does no clock stretching.
- `i2c_sda`  inout  1  bus data, open-drain: driven 0 when `sda_oe`=1, else high-Z.
- `tx_data`  input  8  byte to return on read; sampled when `tx_req` pulses.
- `rx_data`  output  8  last received write byte.
- `rx_valid`  output  1  one-clk pulse, `rx_data` updated.
- `tx_req`  output  1  one-clk pulse, `tx_data` latched into shifter.
- `addr_match`  output  1  high from address ACK until STOP/START.
- `busy`  output  1  high whenever state ≠ IDLE.

## Operation
- Reset values: `sda_oe`=0 (SDA released), `rx_data`=8'h00, `rx_valid`=0, `tx_req`=0, `addr_match`=0, `busy`=0, state=IDLE, bit counter=0, shifter=0.
- SCL and SDA each pass through a 2-flop synchronizer. A third register holds the previous synchronized value. Edge flags compare the sync2 output with that register.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. These take priority over data edges in any state.
- Data is sampled on SCL rise. SDA drive changes only on SCL fall.
- States:
  - IDLE: wait for START, then go to ADDR.
  - ADDR: shift in 8 bits MSB first (7 address bits, then R/W).
    - On 8th rise with address == `SLAVE_ADDR`: go to ADDR_ACK.
    - Otherwise: go to WAIT_STOP, SDA never driven.
  - ADDR_ACK: on next SCL fall, `sda_oe`=1 and `addr_match`=1. On the following fall:
    - Write: release SDA, go to WR_DATA.
    - Read: latch `tx_data`, pulse `tx_req`, drive bit 7, go to RD_DATA.
  - WR_DATA: sample 8 bits. On the 8th rise, `rx_data`←byte and pulse `rx_valid`. Drive ACK on next fall (WR_ACK), release on the fall after, return to WR_DATA. Unlimited byte count.
  - RD_DATA: drive a bit on each SCL fall, shifting MSB first (`sda_oe` = ~bit). Release SDA on the fall after bit 0 and go to RD_ACK.
  - RD_ACK: sample the master's bit on SCL rise.
    - 0 (ACK): on next fall latch `tx_data`, pulse `tx_req`, drive bit 7, back to RD_DATA.
    - 1 (NACK): go to WAIT_STOP.
  - WAIT_STOP: SDA released. STOP goes to IDLE; START goes to ADDR.
- STOP in any state: release SDA, clear `addr_match`, go to IDLE.
- Repeated START in any state: release SDA, clear `addr_match`, reset the bit counter, go to ADDR.
- General-call address (7'h00) is not matched.
- `reset_n` low mid-transfer: SDA is released within the same clk (asynchronous). After release the block waits in IDLE for a fresh START, ignoring the rest of the interrupted transaction.

## Timing
- Bus edge to internal action: 3 clk cycles (2 synchronizer stages + edge register). The state/output update lands on the 3rd rising `clk` edge after the pin change.
- `sda_oe` changes at most 3 clk after an SCL fall. This requires SCL low time ≥ 4 clk, met by the ≥8× ratio.
- `rx_valid` is asserted in the same cycle `rx_data` updates, exactly 1 clk wide.
- `tx_req` is 1 clk wide and coincides with `tx_data` capture; `tx_data` must be stable in that cycle.
- SDA changes while SCL is high, other than START/STOP, are protocol errors; the block treats them as START/STOP per the rules above.

## Test plan
- Write 0x48+W, then byte 0x3C, then STOP. Required: ACK on the 9th clock of both bytes, `rx_data`=8'h3C, exactly one `rx_valid` pulse, `busy` drops 3 clk after STOP.
- Address 0x50+W, then 0xFF. Required: `sda_oe` stays 0 throughout, `addr_match` stays 0, no `rx_valid`, IDLE after STOP.
- Read 0x48+R with `tx_data`=8'hAA and master NACK. Required: SDA pattern 1,0,1,0,1,0,1,0, one `tx_req`, SDA released at the 9th clock, WAIT_STOP→IDLE.
- Two-byte write 0xA5 then 0x5A. Required: two `rx_valid` pulses with `rx_data`=8'hA5 then 8'h5A, ACK on every 9th clock.
- Write 0x48+W, then repeated START, then 0x48+R with master ACK then NACK, `tx_data`=8'h11 then 8'h22. Required: bytes 0x11 and 0x22 on SDA, two `tx_req` pulses.
- `reset_n` asserted while the ACK is being driven. Required: `sda_oe`=0 immediately and all outputs at reset values. After release, no response until a fresh START+address.
